// File: rtl/counter_btn_accel_if.sv
// Board-side bundle for counter_btn_accel: raw active-low buttons in, counter state out.
interface counter_btn_accel_if #(
  parameter int unsigned WIDTH = 8
);
  logic             btn_up_ni;
  logic             btn_down_ni;
  logic             btn_clr_ni;
  logic [WIDTH-1:0] counter_o;
  logic             at_min_o;
  logic             at_max_o;
  logic [1:0]       event_o;

  modport master (
    output btn_up_ni, btn_down_ni, btn_clr_ni,
    input  counter_o, at_min_o, at_max_o, event_o
  );

  modport slave (
    input  btn_up_ni, btn_down_ni, btn_clr_ni,
    output counter_o, at_min_o, at_max_o, event_o
  );
endinterface

// File: rtl/counter_btn_accel.sv
// Push-button up/down/clear counter with per-button sync + debounce, two-speed
// auto-repeat on up/down, and a saturating or wrapping [MIN_VAL,MAX_VAL] range.
module counter_btn_accel #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned STEP         = 10,
  parameter int unsigned MIN_VAL      = 0,
  parameter int unsigned MAX_VAL      = 2**WIDTH - 1,
  parameter bit          SATURATE     = 1'b1,
  parameter int unsigned DEBOUNCE     = 1_000_000,
  parameter int unsigned REPEAT_DELAY = 20_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000,
  parameter int unsigned FAST_RATE    = 1_000_000,
  parameter int unsigned FAST_AFTER   = 8
) (
  input logic                clk_i,
  input logic                reset_ni,
  counter_btn_accel_if.slave bus_if
);

  localparam int unsigned NBTN    = 3;
  localparam int unsigned NRPT    = 2;
  localparam int unsigned CW      = WIDTH + 1;
  localparam int unsigned DB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned RPT_MX1 = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPT_MAX = (RPT_MX1 > FAST_RATE) ? RPT_MX1 : FAST_RATE;
  localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam int unsigned REP_W   = $clog2(FAST_AFTER + 1);

  localparam logic [CW-1:0] MIN_X  = CW'(MIN_VAL);
  localparam logic [CW-1:0] MAX_X  = CW'(MAX_VAL);
  localparam logic [CW-1:0] STEP_X = CW'(STEP);
  localparam logic [CW-1:0] SPAN_X = CW'(MAX_VAL - MIN_VAL + 1);

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_SLOW,
    RPT_FAST
  } rpt_state_e;

  // Index 0 = up, 1 = down, 2 = clear.
  logic [NBTN-1:0] raw_n;
  logic [NBTN-1:0] pressed;
  logic [NRPT-1:0] req_c;

  assign raw_n = {bus_if.btn_clr_ni, bus_if.btn_down_ni, bus_if.btn_up_ni};

  for (genvar i = 0; i < NBTN; i++) begin : g_db
    logic            sync1_q, sync2_q;
    logic            deb_q, deb_d;
    logic [DB_W-1:0] timer_q, timer_d;

    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        deb_q   <= 1'b1;
        timer_q <= '0;
      end else begin
        sync1_q <= raw_n[i];
        sync2_q <= sync1_q;
        deb_q   <= deb_d;
        timer_q <= timer_d;
      end
    end

    // Flip only after DEBOUNCE consecutive cycles of disagreement.
    always_comb begin
      deb_d   = deb_q;
      timer_d = '0;
      if (sync2_q != deb_q) begin
        if (timer_q == DB_W'(DEBOUNCE - 1)) begin
          deb_d = sync2_q;
        end else begin
          timer_d = timer_q + DB_W'(1);
        end
      end
    end

    assign pressed[i] = ~deb_q;
  end

  for (genvar i = 0; i < NRPT; i++) begin : g_rpt
    rpt_state_e       state_q, state_d;
    logic [RPT_W-1:0] timer_q, timer_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             req;

    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        state_q <= RPT_IDLE;
        timer_q <= '0;
        rep_q   <= '0;
      end else begin
        state_q <= state_d;
        timer_q <= timer_d;
        rep_q   <= rep_d;
      end
    end

    // A release drops straight back to idle from any state without a request.
    always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      rep_d   = rep_q;
      req     = 1'b0;
      if (!pressed[i]) begin
        state_d = RPT_IDLE;
        timer_d = '0;
        rep_d   = '0;
      end else begin
        case (state_q)
          RPT_IDLE: begin
            req     = 1'b1;
            state_d = RPT_DELAY;
            timer_d = '0;
            rep_d   = '0;
          end
          RPT_DELAY: begin
            if (timer_q == RPT_W'(REPEAT_DELAY - 1)) begin
              req     = 1'b1;
              timer_d = '0;
              rep_d   = REP_W'(1);
              state_d = (FAST_AFTER <= 1) ? RPT_FAST : RPT_SLOW;
            end else begin
              timer_d = timer_q + RPT_W'(1);
            end
          end
          RPT_SLOW: begin
            if (timer_q == RPT_W'(REPEAT_RATE - 1)) begin
              req     = 1'b1;
              timer_d = '0;
              rep_d   = rep_q + REP_W'(1);
              if (rep_d == REP_W'(FAST_AFTER)) begin
                state_d = RPT_FAST;
              end
            end else begin
              timer_d = timer_q + RPT_W'(1);
            end
          end
          RPT_FAST: begin
            if (timer_q == RPT_W'(FAST_RATE - 1)) begin
              req     = 1'b1;
              timer_d = '0;
            end else begin
              timer_d = timer_q + RPT_W'(1);
            end
          end
          default: begin
            state_d = RPT_IDLE;
          end
        endcase
      end
    end

    assign req_c[i] = req;
  end

  logic             clr_prev_q;
  logic             clr_pulse_c;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic [1:0]       event_q, event_d;
  logic [CW-1:0]    cur_c, up_val_c, dn_val_c;

  assign clr_pulse_c = pressed[2] & ~clr_prev_q;
  assign cur_c       = CW'(counter_q);

  // One extra bit keeps v+STEP and v+SPAN free of overflow.
  always_comb begin
    if (cur_c + STEP_X > MAX_X) begin
      up_val_c = SATURATE ? MAX_X : cur_c + STEP_X - SPAN_X;
    end else begin
      up_val_c = cur_c + STEP_X;
    end
    if (cur_c < MIN_X + STEP_X) begin
      dn_val_c = SATURATE ? MIN_X : cur_c + SPAN_X - STEP_X;
    end else begin
      dn_val_c = cur_c - STEP_X;
    end
  end

  // Clear wins; simultaneous up and down cancel out.
  always_comb begin
    counter_d = counter_q;
    event_d   = 2'b00;
    if (clr_pulse_c) begin
      counter_d = WIDTH'(MIN_VAL);
    end else if (req_c == 2'b01) begin
      counter_d = WIDTH'(up_val_c);
      event_d   = 2'b01;
    end else if (req_c == 2'b10) begin
      counter_d = WIDTH'(dn_val_c);
      event_d   = 2'b10;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      clr_prev_q <= 1'b0;
      counter_q  <= WIDTH'(MIN_VAL);
      event_q    <= 2'b00;
    end else begin
      clr_prev_q <= pressed[2];
      counter_q  <= counter_d;
      event_q    <= event_d;
    end
  end

  assign bus_if.counter_o = counter_q;
  assign bus_if.event_o   = event_q;
  assign bus_if.at_min_o  = (counter_q == WIDTH'(MIN_VAL));
  assign bus_if.at_max_o  = (counter_q == WIDTH'(MAX_VAL));

endmodule
